// File: rtl/mult_err_pkg.sv
// Shared defaults and FSM encoding for the approximate-multiplier error statistics block.
package mult_err_pkg;

    localparam int W_DEF  = 16;
    localparam int CW_DEF = 33;
    localparam int SW_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_err_dist.sv
// Exact unsigned product of a and b, and its absolute distance from the approximate product y.
module mult_err_dist #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2*W-1:0] y,
    output logic [2*W-1:0] ed,
    output logic           mismatch
);

    logic [2*W-1:0] exact;

    assign exact    = (2*W)'(a) * (2*W)'(b);
    assign ed       = (exact >= y) ? (exact - y) : (y - exact);
    assign mismatch = (ed != '0);

endmodule

// File: rtl/mult_err_stats.sv
// Error statistics collector for an approximate multiplier: a three-step
// pipeline (capture, distance, accumulate) driven by an IDLE/RUN/DRAIN/DONE FSM.
module mult_err_stats
    import mult_err_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [2*W-1:0]  y,
    input  logic            in_last,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   sample_cnt,
    output logic [CW-1:0]   err_cnt,
    output logic [SW-1:0]   sum_ed,
    output logic [2*W-1:0]  max_ed,
    output logic [W-1:0]    max_a,
    output logic [W-1:0]    max_b
);

    state_t         state_q, state_d;

    logic           v0_q, v0_d;
    logic [W-1:0]   a0_q, a0_d, b0_q, b0_d;
    logic [2*W-1:0] y0_q, y0_d;

    logic           v1_q, v1_d;
    logic           mis1_q, mis1_d;
    logic [2*W-1:0] ed1_q, ed1_d;
    logic [W-1:0]   a1_q, a1_d, b1_q, b1_d;

    logic [CW-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CW-1:0]  err_cnt_q, err_cnt_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic [2*W-1:0] max_ed_q, max_ed_d;
    logic [W-1:0]   max_a_q, max_a_d, max_b_q, max_b_d;

    logic [2*W-1:0] ed0;
    logic           mis0;
    logic           accept;
    logic           clear;
    logic [SW:0]    sum_ext;

    mult_err_dist #(.W(W)) u_dist (
        .a        (a0_q),
        .b        (b0_q),
        .y        (y0_q),
        .ed       (ed0),
        .mismatch (mis0)
    );

    assign accept = in_valid && (state_q == ST_RUN);
    assign clear  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d      = state_q;
        v0_d         = accept;
        a0_d         = a0_q;
        b0_d         = b0_q;
        y0_d         = y0_q;
        v1_d         = v0_q;
        mis1_d       = mis1_q;
        ed1_d        = ed1_q;
        a1_d         = a1_q;
        b1_d         = b1_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_d        = sum_q;
        max_ed_d     = max_ed_q;
        max_a_d      = max_a_q;
        max_b_d      = max_b_q;
        sum_ext      = {1'b0, sum_q} + (SW+1)'(ed1_q);

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (!v0_q && !v1_q) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            a0_d = a;
            b0_d = b;
            y0_d = y;
        end

        if (v0_q) begin
            ed1_d  = ed0;
            mis1_d = mis0;
            a1_d   = a0_q;
            b1_d   = b0_q;
        end

        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_d        = '0;
            max_ed_d     = '0;
            max_a_d      = '0;
            max_b_d      = '0;
        end else if (v1_q) begin
            // All counters stick at all-ones instead of wrapping.
            if (!(&sample_cnt_q)) sample_cnt_d = sample_cnt_q + CW'(1);
            if (mis1_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CW'(1);
            sum_d = sum_ext[SW] ? '1 : sum_ext[SW-1:0];
            if (ed1_q > max_ed_q) begin
                max_ed_d = ed1_q;
                max_a_d  = a1_q;
                max_b_d  = b1_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            v0_q         <= 1'b0;
            a0_q         <= '0;
            b0_q         <= '0;
            y0_q         <= '0;
            v1_q         <= 1'b0;
            mis1_q       <= 1'b0;
            ed1_q        <= '0;
            a1_q         <= '0;
            b1_q         <= '0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_q        <= '0;
            max_ed_q     <= '0;
            max_a_q      <= '0;
            max_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            v0_q         <= v0_d;
            a0_q         <= a0_d;
            b0_q         <= b0_d;
            y0_q         <= y0_d;
            v1_q         <= v1_d;
            mis1_q       <= mis1_d;
            ed1_q        <= ed1_d;
            a1_q         <= a1_d;
            b1_q         <= b1_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_q        <= sum_d;
            max_ed_q     <= max_ed_d;
            max_a_q      <= max_a_d;
            max_b_q      <= max_b_d;
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_q;
    assign max_ed     = max_ed_q;
    assign max_a      = max_a_q;
    assign max_b      = max_b_q;

endmodule

// File: tb/tb_mult_err_stats.sv
// Scoreboard bench: each run's expected final statistics and done cycle are queued
// by the stimulus; a negedge monitor checks them when done rises.
module tb_mult_err_stats;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0;
    logic [31:0] y = '0;
    logic        in_last = 1'b0;
    logic        busy, done;
    logic [32:0] sample_cnt, err_cnt;
    logic [63:0] sum_ed;
    logic [31:0] max_ed;
    logic [15:0] max_a, max_b;

    mult_err_stats dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .y(y), .in_last(in_last), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed),
        .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] cnt;
        logic [32:0] err;
        logic [63:0] sum;
        logic [31:0] med;
        logic [15:0] ma;
        logic [15:0] mb;
        int          dcyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic done_d = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: cyc read before increment equals the index of the preceding rising edge.
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.dcyc));
                chk("sample_cnt", 64'(sample_cnt), 64'(e.cnt));
                chk("err_cnt", 64'(err_cnt), 64'(e.err));
                chk("sum_ed", sum_ed, e.sum);
                chk("max_ed", 64'(max_ed), 64'(e.med));
                chk("max_a", 64'(max_a), 64'(e.ma));
                chk("max_b", 64'(max_b), 64'(e.mb));
            end
        end
        done_d = done;
        cyc++;
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic [31:0] ty,
                        input logic tl, output int k);
        a = ta; b = tb; y = ty; in_last = tl; in_valid = 1'b1;
        @(posedge clk);
        k = cyc;
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [32:0] c, input logic [32:0] er, input logic [63:0] s,
                        input logic [31:0] m, input logic [15:0] ma, input logic [15:0] mb,
                        input int dc);
        exp_t x;
        x.cnt = c; x.err = er; x.sum = s; x.med = m; x.ma = ma; x.mb = mb; x.dcyc = dc;
        exp_q.push_back(x);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got done=0 after 20 cycles, expected 1");
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd0);

        // Run 1: one exact sample, one off by 3.
        pulse_start();
        chk("run_in_ready", 64'(in_ready), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        send(16'd3, 16'd5, 32'd15, 1'b0, k);
        send(16'd7, 16'd9, 32'd60, 1'b1, k);
        push(33'd2, 33'd1, 64'd3, 32'd3, 16'd7, 16'd9, k + 3);
        wait_done();

        // Run 2: bubbles between samples, start pulses in RUN and DRAIN, tie on max.
        pulse_start();
        chk("clear_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("clear_sum_ed", sum_ed, 64'd0);
        chk("clear_max_ed", 64'(max_ed), 64'd0);
        send(16'd2, 16'd3, 32'd7, 1'b0, k);
        pulse_start();
        send(16'd4, 16'd5, 32'd16, 1'b0, k);
        chk("latency_sample_cnt", 64'(sample_cnt), 64'd1);
        chk("latency_sum_ed", sum_ed, 64'd1);
        @(posedge clk);
        #1;
        send(16'd10, 16'd10, 32'd104, 1'b0, k);
        @(posedge clk);
        #1;
        send(16'd6, 16'd6, 32'd34, 1'b1, k);
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        push(33'd4, 33'd4, 64'd11, 32'd4, 16'd4, 16'd5, k + 3);
        a = 16'd100; b = 16'd100; y = 32'd0; in_valid = 1'b1;
        pulse_start();
        in_valid = 1'b0;
        wait_done();

        // Run 3: worst-case distance for 16-bit operands.
        pulse_start();
        send(16'hFFFF, 16'hFFFF, 32'd0, 1'b1, k);
        push(33'd1, 33'd1, 64'hFFFE0001, 32'hFFFE0001, 16'hFFFF, 16'hFFFF, k + 3);
        wait_done();

        // in_valid in DONE is ignored and the stats hold.
        @(posedge clk);
        #1;
        a = 16'd1; b = 16'd1; y = 32'd9; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold_sample_cnt", 64'(sample_cnt), 64'd1);
        chk("done_hold_max_ed", 64'(max_ed), 64'hFFFE0001);
        chk("done_hold_done", 64'(done), 64'd1);

        // Run 4: reset mid-run discards everything.
        pulse_start();
        send(16'd1, 16'd1, 32'd1, 1'b0, k);
        send(16'd2, 16'd2, 32'd5, 1'b0, k);
        send(16'd3, 16'd3, 32'd9, 1'b0, k);
        send(16'd4, 16'd4, 32'd16, 1'b0, k);
        send(16'd5, 16'd5, 32'd25, 1'b0, k);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_sample_cnt", 64'(sample_cnt), 64'd5);
        chk("pre_rst_sum_ed", sum_ed, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_sample_cnt", 64'(sample_cnt), 64'd0);
        chk("async_rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("async_rst_sum_ed", sum_ed, 64'd0);
        chk("async_rst_max_ed", 64'(max_ed), 64'd0);
        chk("async_rst_max_a", 64'(max_a), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_in_ready", 64'(in_ready), 64'd0);
        end
        pulse_start();
        send(16'd8, 16'd8, 32'd60, 1'b1, k);
        push(33'd1, 33'd1, 64'd4, 32'd4, 16'd8, 16'd8, k + 3);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_err_stats.md
MULT_ERR_STATS -- requirements
Module: mult_err_stats

Interface
REQ-001 Parameter W, default 16, operand width of the approximate multiplier under test.
REQ-002 Parameter CW, default 33, width of the sample and error counters (holds 2^32 samples).
REQ-003 Parameter SW, default 64, width of the error-distance sum.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  one-cycle pulse that clears the statistics and begins a run.
REQ-007 in_valid  input  1  a, b, y and in_last are valid this cycle.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 a, b  input  W each  operands fed to the multiplier.
REQ-010 y  input  2W  approximate product from the multiplier.
REQ-011 in_last  input  1  marks the final sample of the run.
REQ-012 busy  output  1  high in RUN or DRAIN.
REQ-013 done  output  1  high while in DONE.
REQ-014 sample_cnt, err_cnt  output  CW each  counts of accepted samples and of samples with y != a*b.
REQ-015 sum_ed  output  SW  sum of |a*b - y| over accepted samples.
REQ-016 max_ed  output  2W  largest error distance seen in the run.
REQ-017 max_a, max_b  output  W each  operands that produced max_ed.

Function
REQ-018 The FSM shall have the states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE or DONE with start=1 shall zero all statistics and move to RUN on the next edge.
REQ-020 start shall be ignored in RUN and DRAIN.
REQ-021 in_ready shall be high only in RUN.
REQ-022 A sample shall be accepted on each edge where in_valid and in_ready are both high; the block never back-pressures within RUN.
REQ-023 Accepting a sample with in_last=1 shall move the FSM to DRAIN.
REQ-024 DRAIN shall move to DONE when the pipeline holds no valid sample.
REQ-025 DONE shall hold all statistics stable until the next start.
REQ-026 The pipeline shall have three steps:
- edge k (accept): register a, b, y and the exact product a*b (2W bits, unsigned).
- edge k+1: register ed = |exact - y| and mismatch = (ed != 0).
- edge k+2: update the accumulators.
REQ-027 A sample accepted at edge k shall be visible on the outputs after edge k+2.
REQ-028 A last sample accepted at edge k shall make done rise after edge k+3.
REQ-029 sample_cnt and err_cnt shall saturate at 2^CW-1.
REQ-030 sum_ed shall saturate at 2^SW-1.
REQ-031 max_ed, max_a and max_b shall update only when ed > max_ed (strictly greater); on a tie the earliest sample is kept.
REQ-032 max_ed=0 shall report max_a=0 and max_b=0.
REQ-033 A cycle with in_valid low in RUN shall insert a bubble that leaves every accumulator unchanged.
REQ-034 in_valid in IDLE, DRAIN or DONE shall be ignored, and no sample is counted.

Reset
REQ-035 rst=1 shall immediately force state=IDLE, clear the pipeline valids, and zero every statistic output, busy and done.
REQ-036 A run in progress when rst asserts shall be discarded.
REQ-037 After rst deasserts, the block shall wait in IDLE for start.

Structure
REQ-038 The shared package mult_err_pkg shall hold the defaults for W, CW and SW and the FSM state enum.
REQ-039 The combinational exact-product and absolute-difference logic shall be one sub-module, mult_err_dist, with inputs a, b, y and outputs ed and mismatch.
REQ-040 The FSM, pipeline registers and accumulators shall reside in mult_err_stats.

Verification
REQ-041 Reset then start, then accept samples (3,5,y=15) and (7,9,y=60) with the second as last -> sample_cnt=2, err_cnt=1, sum_ed=3, max_ed=3, max_a=7, max_b=9, done high after edge k+3.
REQ-042 Start, then feed in_valid every other cycle for 4 samples with ed 1, 4, 4, 2 -> max_ed=4, max_a/max_b from the first ed=4 sample, sum_ed=11, sample_cnt=4.
REQ-043 Feed (65535,65535,y=0) as a single last sample -> max_ed=32'hFFFE0001 and sum_ed=32'hFFFE0001.
REQ-044 Assert rst two cycles after 5 accepted samples -> all outputs 0 and state IDLE immediately, then in_ready stays low until start.
REQ-045 Pulse start during RUN and during DRAIN -> both ignored, counts unaffected.
REQ-046 Pulse start in DONE -> stats zeroed after one edge, and a new run is accepted.
